pc_npc_unit: RTL
================

Name: pc_npc_unit

Overview:
- Parametrised successor to the single PC register. Holds the SPARC PC/nPC pair and implements delayed-branch sequencing, annulled delay slots, trap entry with PC/nPC save, and trap retry.
- Includes a DEPTH-entry ring-buffer trace of retired PC values. The trace replaces file logging and is readable in hardware and in simulation.
- Sits in the fetch stage. The control unit drives its qualifiers, and the instruction memory address is taken from PC.

Parameters:
- WIDTH, 32, PC/nPC/address width in bits (minimum 8).
- RESET_VECTOR, 0, PC value after reset. nPC resets to RESET_VECTOR+4.
- DEPTH, 8, number of trace entries (power of two, 2..64).
- IDX_W, 3, trace index width, log2(DEPTH).

Ports:
- Clock  input  1  system clock. All state updates on the falling edge.
- Reset_N  input  1  asynchronous, active-low reset.
- Load_Enable  input  1  advance PC/nPC this edge.
- Branch_Taken  input  1  control transfer taken (valid only with Load_Enable).
- Annul  input  1  annul bit of the current branch (valid only with Load_Enable).
- Target  input  WIDTH  branch/jump target address.
- Trap  input  1  trap entry request.
- Trap_Addr  input  WIDTH  trap handler address.
- Retry  input  1  return from trap, resuming at the saved PC/nPC.
- Trace_Index  input  IDX_W  trace read index. 0 = most recent entry.
- PC  output  WIDTH  current program counter.
- nPC  output  WIDTH  next program counter.
- Saved_PC  output  WIDTH  PC captured at trap entry.
- Saved_nPC  output  WIDTH  nPC captured at trap entry.
- Trace_PC  output  WIDTH  trace entry at Trace_Index (combinational read).
- Trace_Count  output  IDX_W+1  number of valid trace entries, saturating at DEPTH.
- Misaligned  output  1  sticky flag: a misaligned PC has been loaded.

Behaviour:
- Reset (Reset_N=0, asynchronous, any time including mid-sequence):
  - PC=RESET_VECTOR, nPC=RESET_VECTOR+4.
  - Saved_PC=Saved_nPC=0.
  - Trace write pointer=0, Trace_Count=0, Misaligned=0.
  - Trace storage contents are don't-care.
- All other updates occur on the falling edge of Clock, with zero latency: new values are visible right after the edge.
- Priority per edge: Trap > Retry > Load_Enable. Lower-priority requests in the same edge are ignored.
- Trap:
  - Saved_PC<=PC, Saved_nPC<=nPC.
  - PC<=Trap_Addr, nPC<=Trap_Addr+4.
  - Misaligned<=0, evaluated against the new PC.
- Retry: PC<=Saved_PC, nPC<=Saved_nPC. Saved registers are unchanged.
- Load_Enable, selected by {Branch_Taken, Annul}:
  - 00: PC<=nPC, nPC<=nPC+4.
  - 10: PC<=nPC, nPC<=Target (delay slot executes).
  - 11: PC<=Target, nPC<=Target+4 (delay slot annulled).
  - 01: PC<=nPC+4, nPC<=nPC+8 (untaken branch, delay slot annulled).
- No request active: all state holds.
- Arithmetic: all additions are modulo 2^WIDTH; wrap-around is silent and no flag is raised.
- Misaligned:
  - Set when any update loads a PC whose bits[1:0] are nonzero.
  - Cleared only by Trap (re-evaluated against Trap_Addr) or by reset.
  - The PC value itself is loaded unmodified.
- Trace buffer:
  - On every edge where PC updates (Trap, Retry or Load_Enable), the old PC is written at the write pointer.
  - Pointer increments modulo DEPTH, overwriting the oldest entry.
  - Trace_Count increments on each write and saturates at DEPTH.
  - Trace_PC = entry (ptr-1-Trace_Index) mod DEPTH when Trace_Index < Trace_Count, otherwise 0.
- Branch_Taken/Annul without Load_Enable: no effect.
- Target and Trap_Addr are sampled only on the edge that uses them.

Test Plan:
- Reset release with RESET_VECTOR=0x100 -> PC=0x100, nPC=0x104, Trace_Count=0. Three plain advances -> PC=0x10C, nPC=0x110, Trace_Count=3, Trace_PC[0]=0x108, [2]=0x100, [3]=0.
- From PC=0x200/nPC=0x204:
  - Taken branch Target=0x400, Annul=0 -> PC=0x204, nPC=0x400, then advance -> PC=0x400, nPC=0x404.
  - Same with Annul=1 -> PC=0x400, nPC=0x404.
  - Untaken with Annul=1 -> PC=0x208, nPC=0x20C.
- Trap at PC=0x300/nPC=0x304, Trap_Addr=0x800, with Load_Enable also asserted -> PC=0x800, nPC=0x804, Saved_PC=0x300, Saved_nPC=0x304. Two advances, then Retry -> PC=0x300, nPC=0x304.
- Taken branch to Target=0x502 -> Misaligned=1 and stays 1 across advances. Trap to 0x900 -> Misaligned=0.
- Wrap and overflow:
  - PC=0xFFFFFFF8/nPC=0xFFFFFFFC, advance -> nPC=0x00000000.
  - DEPTH=8, 10 advances -> Trace_Count=8 and the oldest two PCs are gone.
- Reset_N asserted between clock edges, mid-sequence after a trap -> outputs return to reset values immediately, before the next edge.

Source files
------------

// File: rtl/pc_npc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_npc_unit
//  Purpose  : SPARC PC/nPC pair with delayed-branch sequencing, annulled
//             delay slots, trap entry with PC/nPC save, trap retry, a sticky
//             misalignment flag and a ring-buffer trace of retired PCs.
//  Revision : 1.0  initial release
// ============================================================================
module pc_npc_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned      DEPTH        = 8,
  parameter int unsigned      IDX_W        = 3
) (
  input  logic             Clock,
  input  logic             Reset_N,
  input  logic             Load_Enable,
  input  logic             Branch_Taken,
  input  logic             Annul,
  input  logic [WIDTH-1:0] Target,
  input  logic             Trap,
  input  logic [WIDTH-1:0] Trap_Addr,
  input  logic             Retry,
  input  logic [IDX_W-1:0] Trace_Index,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] nPC,
  output logic [WIDTH-1:0] Saved_PC,
  output logic [WIDTH-1:0] Saved_nPC,
  output logic [WIDTH-1:0] Trace_PC,
  output logic [IDX_W:0]   Trace_Count,
  output logic             Misaligned
);

  localparam logic [WIDTH-1:0] C_FOUR  = WIDTH'(4);
  localparam logic [WIDTH-1:0] C_EIGHT = WIDTH'(8);
  localparam logic [IDX_W:0]   C_DEPTH = (IDX_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_npc;
  logic [WIDTH-1:0] r_saved_pc;
  logic [WIDTH-1:0] r_saved_npc;
  logic             r_misaligned;
  logic [IDX_W-1:0] r_wr_ptr;
  logic [IDX_W:0]   r_count;
  logic [WIDTH-1:0] r_trace [DEPTH];

  logic [WIDTH-1:0] w_pc_next;
  logic [WIDTH-1:0] w_npc_next;
  logic             w_update;
  logic             w_mis_next;
  logic [IDX_W-1:0] w_rd_idx;

  // Next PC/nPC selection; Trap outranks Retry, which outranks Load_Enable
  always_comb begin
    w_pc_next  = r_pc;
    w_npc_next = r_npc;
    w_update   = 1'b0;
    if (Trap) begin
      w_pc_next  = Trap_Addr;
      w_npc_next = Trap_Addr + C_FOUR;
      w_update   = 1'b1;
    end else if (Retry) begin
      w_pc_next  = r_saved_pc;
      w_npc_next = r_saved_npc;
      w_update   = 1'b1;
    end else if (Load_Enable) begin
      w_update = 1'b1;
      case ({Branch_Taken, Annul})
        2'b10: begin  // taken, delay slot executes
          w_pc_next  = r_npc;
          w_npc_next = Target;
        end
        2'b11: begin  // taken, delay slot annulled
          w_pc_next  = Target;
          w_npc_next = Target + C_FOUR;
        end
        2'b01: begin  // untaken, delay slot annulled: skip it
          w_pc_next  = r_npc + C_FOUR;
          w_npc_next = r_npc + C_EIGHT;
        end
        default: begin  // sequential advance
          w_pc_next  = r_npc;
          w_npc_next = r_npc + C_FOUR;
        end
      endcase
    end
  end

  // Sticky misalignment: a trap restarts the flag from the handler address
  always_comb begin
    w_mis_next = r_misaligned;
    if (Trap)
      w_mis_next = |Trap_Addr[1:0];
    else if (w_update)
      w_mis_next = r_misaligned | (|w_pc_next[1:0]);
  end

  // Architectural state, updated on the falling edge
  always_ff @(negedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      r_pc         <= RESET_VECTOR;
      r_npc        <= RESET_VECTOR + C_FOUR;
      r_saved_pc   <= '0;
      r_saved_npc  <= '0;
      r_misaligned <= 1'b0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
    end else begin
      r_pc         <= w_pc_next;
      r_npc        <= w_npc_next;
      r_misaligned <= w_mis_next;
      if (Trap) begin
        r_saved_pc  <= r_pc;
        r_saved_npc <= r_npc;
      end
      if (w_update) begin
        r_wr_ptr <= r_wr_ptr + IDX_W'(1);
        if (r_count != C_DEPTH)
          r_count <= r_count + (IDX_W+1)'(1);
      end
    end
  end

  // Trace storage: contents need no reset, validity is tracked by r_count
  always_ff @(negedge Clock) begin
    if (w_update)
      r_trace[r_wr_ptr] <= r_pc;
  end

  // Index 0 is the newest entry; the pointer wraps naturally at DEPTH
  assign w_rd_idx = r_wr_ptr - IDX_W'(1) - Trace_Index;

  assign Trace_PC    = ({1'b0, Trace_Index} < r_count) ? r_trace[w_rd_idx] : '0;
  assign PC          = r_pc;
  assign nPC         = r_npc;
  assign Saved_PC    = r_saved_pc;
  assign Saved_nPC   = r_saved_npc;
  assign Trace_Count = r_count;
  assign Misaligned  = r_misaligned;

endmodule
`default_nettype wire
